// File: rtl/ifetch_unit.sv
// ifetch_unit: PC register, imem address drive and {pc,instr} fetch buffer.
// Optional IFETCH_MISALIGN_EN adds a sticky misalign_fault that freezes fetch.
module ifetch_unit #(
  parameter int n = 32,
  parameter int r = 6,
  parameter int DEPTH = 2,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [r-1:0]               imem_addr,
  input  logic [n-1:0]               imem_rdata,
  input  logic                       redirect_valid,
  input  logic [n-1:0]               redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [n-1:0]               out_instr,
  output logic [n-1:0]               out_pc,
`ifdef IFETCH_MISALIGN_EN
  output logic                       misalign_fault,
`endif
  output logic [$clog2(DEPTH):0]     fetch_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [n-1:0]   r_pc;
  logic [2*n-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_rd;
  logic [AW-1:0]  r_wr;
  logic [CW-1:0]  r_cnt;

  logic w_pop;
  logic w_push;
  logic w_redir;
  logic w_bad;
  logic w_frz;

`ifdef IFETCH_MISALIGN_EN
  logic r_fault;

  assign w_redir = redirect_valid && !r_fault;
  assign w_bad   = w_redir && (redirect_pc[1:0] != 2'b00);
  assign w_frz   = r_fault;
  assign misalign_fault = r_fault;

  // Fault latches on the first misaligned redirect and holds until reset
  always_ff @(posedge clk) begin
    if (reset)
      r_fault <= 1'b0;
    else if (w_bad)
      r_fault <= 1'b1;
  end
`else
  assign w_redir = redirect_valid;
  assign w_bad   = 1'b0;
  assign w_frz   = 1'b0;
`endif

  assign w_pop  = out_valid && out_ready;
  assign w_push = !redirect_valid && !w_frz &&
                  ((r_cnt < CW'(DEPTH)) || w_pop);

  assign imem_addr   = r_pc[r+1:2];
  assign out_valid   = (r_cnt != '0);
  assign fetch_count = r_cnt;
  assign {out_pc, out_instr} = r_mem[r_rd];

  // PC: reset, redirect target, or advance by one word on each push
  always_ff @(posedge clk) begin
    if (reset)
      r_pc <= RESET_PC;
    else if (w_redir && !w_bad)
      r_pc <= redirect_pc;
    else if (w_push)
      r_pc <= r_pc + n'(4);
  end

  // Fetch buffer: circular storage, flushed by redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_redir) begin
      r_cnt <= '0;
      r_wr  <= r_rd;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {r_pc, imem_rdata};
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scoreboard bench for ifetch_unit.
// Expected {pc,instr} stream is queued by the bench and checked on each pop.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [1:0]  fetch_count;
`ifdef IFETCH_MISALIGN_EN
  logic        misalign_fault;
`endif

  logic [31:0] ram [64];
  logic [31:0] exp_q [$];
  int total = 0;
  int bad = 0;

  assign imem_rdata = ram[imem_addr];

  always #5 clk = ~clk;

  ifetch_unit #(.n(32), .r(6), .DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .reset(reset),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
`ifdef IFETCH_MISALIGN_EN
    .misalign_fault(misalign_fault),
`endif
    .fetch_count(fetch_count)
  );

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return 32'h100 + {26'd0, pc[7:2]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    logic [31:0] e;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb observed=pop expected=empty_queue", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_pc"}, out_pc, e);
      chk({tag, "_instr"}, out_instr, exp_instr(e));
    end
  endtask

  task automatic queue_from(input logic [31:0] pc, input int k);
    exp_q.delete();
    for (int i = 0; i < k; i++)
      exp_q.push_back(pc + 32'(4 * i));
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      ram[i] = 32'h100 + 32'(i);
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {30'd0, fetch_count}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr", {26'd0, imem_addr}, 32'd0);

    // streaming with out_ready high
    reset = 1'b0;
    out_ready = 1'b1;
    queue_from(32'h0, 5);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("str_count", {30'd0, fetch_count}, 32'd1);
      sb_pop("str");
      tick();
    end

    // back-pressure fills the buffer
    reset = 1'b1;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("bp_c1", {30'd0, fetch_count}, 32'd1);
    chk("bp_pc1", out_pc, 32'd0);
    tick();
    chk("bp_c2", {30'd0, fetch_count}, 32'd2);
    chk("bp_addr2", {26'd0, imem_addr}, 32'd2);
    tick();
    tick();
    chk("bp_c4", {30'd0, fetch_count}, 32'd2);
    chk("bp_addr4", {26'd0, imem_addr}, 32'd2);
    chk("bp_pc4", out_pc, 32'd0);
    out_ready = 1'b1;
    queue_from(32'h0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("full_count", {30'd0, fetch_count}, 32'd2);
      sb_pop("full");
      tick();
    end

    // redirect with full buffer
    out_ready = 1'b0;
    tick();
    chk("pre_rd_count", {30'd0, fetch_count}, 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("rd_valid", {31'd0, out_valid}, 32'd0);
    chk("rd_count", {30'd0, fetch_count}, 32'd0);
    chk("rd_addr", {26'd0, imem_addr}, 32'd16);
    queue_from(32'h40, 3);
    tick();
    for (int i = 0; i < 3; i++) begin
      sb_pop("rd");
      tick();
    end

    // redirect across the memory wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'hFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_valid", {31'd0, out_valid}, 32'd0);
    chk("wrap_addr", {26'd0, imem_addr}, 32'd63);
    queue_from(32'hFC, 3);
    tick();
    for (int i = 0; i < 3; i++) begin
      sb_pop("wrap");
      tick();
    end

    // reset beats a simultaneous redirect
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("rr_full", {30'd0, fetch_count}, 32'd2);
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    reset = 1'b0;
    redirect_valid = 1'b0;
    chk("rr_valid", {31'd0, out_valid}, 32'd0);
    chk("rr_count", {30'd0, fetch_count}, 32'd0);
    chk("rr_addr", {26'd0, imem_addr}, 32'd0);
    tick();
    chk("rr_pc", out_pc, 32'd0);
    chk("rr_instr", out_instr, 32'h100);

`ifdef IFETCH_MISALIGN_EN
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    chk("mis_fault", {31'd0, misalign_fault}, 32'd1);
    chk("mis_valid", {31'd0, out_valid}, 32'd0);
    tick();
    tick();
    chk("mis_valid2", {31'd0, out_valid}, 32'd0);
    chk("mis_addr", {26'd0, imem_addr}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("mis_fault2", {31'd0, misalign_fault}, 32'd1);
    chk("mis_addr2", {26'd0, imem_addr}, 32'd1);
    chk("mis_valid3", {31'd0, out_valid}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
